// File: rtl/dffnrsnq_notifier_gen_pkg.sv
// Shared definitions for the dffnrsnq notifier generator: violation codes,
// count width and the priority encoder used when several checks fire at once.
package dffnrsnq_notifier_gen_pkg;

    localparam int CNT_W = 16;

    localparam logic [2:0] VC_NONE  = 3'd0;
    localparam logic [2:0] VC_SETUP = 3'd1;
    localparam logic [2:0] VC_HOLD  = 3'd2;
    localparam logic [2:0] VC_REC   = 3'd3;
    localparam logic [2:0] VC_REM   = 3'd4;
    localparam logic [2:0] VC_PW    = 3'd5;

    // Priority: pulse width > recovery > removal > setup > hold
    function automatic logic [2:0] viol_encode(
        input logic pw,
        input logic rec,
        input logic rem,
        input logic setup,
        input logic hold
    );
        logic [2:0] code;
        code = VC_NONE;
        if (pw)         code = VC_PW;
        else if (rec)   code = VC_REC;
        else if (rem)   code = VC_REM;
        else if (setup) code = VC_SETUP;
        else if (hold)  code = VC_HOLD;
        return code;
    endfunction

endpackage

// File: rtl/dffnrsnq_notifier_gen_sat_age_counter.sv
// Saturating age counter: 'age' is the tick distance since the last clr event,
// not counting a clr in the current tick.
module sat_age_counter #(
    parameter int AGE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [AGE_W-1:0] age
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;

    always_comb begin
        age = age_q;
        if (inc && (age_q != AGE_MAX)) begin
            age = age_q + 1'b1;
        end
        age_d = clr ? '0 : age;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= AGE_MAX;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/dffnrsnq_notifier_gen.sv
// Oversampled timing-check monitor producing the NOTIFIER toggle for the
// dffnrsnq flop models, plus a violation code, count and sticky flag.
module dffnrsnq_notifier_gen
    import dffnrsnq_notifier_gen_pkg::*;
#(
    parameter int SETUP_TICKS  = 2,
    parameter int HOLD_TICKS   = 1,
    parameter int RECREM_TICKS = 2,
    parameter int MINPW_TICKS  = 3,
    parameter int AGE_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLKN_S,
    input  logic             D_S,
    input  logic             RN_S,
    input  logic             SETN_S,
    output logic             NOTIFIER,
    output logic [2:0]       VIOL_CODE,
    output logic [CNT_W-1:0] VIOL_CNT,
    output logic             VIOL_STICKY
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic             clkn_q, d_q, rn_q, setn_q;
    logic [AGE_W-1:0] hold_q, hold_d;
    logic [AGE_W-1:0] rem_q, rem_d;
    logic             notif_q, notif_d;
    logic             sticky_q, sticky_d;
    logic [2:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             act_edge, any_edge, d_chg, deassert, chk_en;
    logic [AGE_W-1:0] d_age, da_age, ph_age;
    logic [AGE_W-1:0] d_age_eff, da_age_eff;
    logic             v_pw, v_rec, v_rem, v_setup, v_hold, v_any;

    assign act_edge = clkn_q && !CLKN_S;
    assign any_edge = clkn_q ^ CLKN_S;
    assign d_chg    = d_q ^ D_S;
    assign deassert = (RN_S && !rn_q) || (SETN_S && !setn_q);
    assign chk_en   = RN_S && SETN_S;

    sat_age_counter #(.AGE_W(AGE_W)) u_d_age (
        .clk(CLK), .rst(RST), .clr(d_chg), .inc(1'b1), .age(d_age)
    );

    sat_age_counter #(.AGE_W(AGE_W)) u_da_age (
        .clk(CLK), .rst(RST), .clr(deassert), .inc(1'b1), .age(da_age)
    );

    sat_age_counter #(.AGE_W(AGE_W)) u_ph_age (
        .clk(CLK), .rst(RST), .clr(any_edge), .inc(1'b1), .age(ph_age)
    );

    always_comb begin
        // An event coinciding with the active edge has age 0
        d_age_eff  = d_chg ? '0 : d_age;
        da_age_eff = deassert ? '0 : da_age;

        v_pw    = any_edge && (ph_age < AGE_W'(MINPW_TICKS)) && (ph_age != AGE_MAX);
        v_rec   = chk_en && act_edge && (da_age_eff < AGE_W'(RECREM_TICKS));
        v_rem   = deassert && !act_edge && (rem_q != '0);
        v_setup = chk_en && act_edge && (d_age_eff < AGE_W'(SETUP_TICKS));
        v_hold  = chk_en && !act_edge && (hold_q != '0) && d_chg;
        v_any   = v_pw || v_rec || v_rem || v_setup || v_hold;

        hold_d = hold_q;
        if (act_edge) begin
            hold_d = AGE_W'(HOLD_TICKS);
        end else if ((hold_q != '0) && d_chg) begin
            hold_d = '0;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end

        rem_d = rem_q;
        if (act_edge) begin
            rem_d = AGE_W'(RECREM_TICKS);
        end else if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
        end

        notif_d  = notif_q ^ v_any;
        sticky_d = sticky_q | v_any;
        code_d   = v_any ? viol_encode(v_pw, v_rec, v_rem, v_setup, v_hold) : code_q;
        cnt_d    = cnt_q;
        if (v_any && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Previous-sample registers track the inputs even in reset, so the first
    // tick after reset never sees a false edge.
    always_ff @(posedge CLK) begin
        clkn_q <= CLKN_S;
        d_q    <= D_S;
        rn_q   <= RN_S;
        setn_q <= SETN_S;
        if (RST) begin
            hold_q   <= '0;
            rem_q    <= '0;
            notif_q  <= 1'b0;
            sticky_q <= 1'b0;
            code_q   <= VC_NONE;
            cnt_q    <= '0;
        end else begin
            hold_q   <= hold_d;
            rem_q    <= rem_d;
            notif_q  <= notif_d;
            sticky_q <= sticky_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
        end
    end

    assign NOTIFIER    = notif_q;
    assign VIOL_CODE   = code_q;
    assign VIOL_CNT    = cnt_q;
    assign VIOL_STICKY = sticky_q;

endmodule
